// File: rtl/instr_loader_ctrl.sv
// Boot-loader and access sequencer for a 256x16 instruction memory: loads a
// length-prefixed big-endian byte stream into memory, then hands the read port to the CPU.
`timescale 1ns/1ps

module instr_loader_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              cpu_stall,
    output logic              load_busy,
    output logic              load_done,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state,
    output logic [ADDR_W-1:0] dbg_wr_ptr
);

    typedef enum logic [2:0] {
        S_BOOT    = 3'd0,
        S_GET_LEN = 3'd1,
        S_GET_HI  = 3'd2,
        S_GET_LO  = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5,
        S_RUN     = 3'd6
    } state_t;

    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(256);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W:0]     r_remaining;
    logic [ADDR_W:0]     r_words;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [7:0]          r_hi;
    logic [DATA_W-1:0]   r_word;
    logic                w_xfer;
    logic [ADDR_W:0]     w_len;

    // Handshake: a byte moves on any rising edge where byte_valid and
    // byte_ready are both high; byte_ready depends only on state, never on byte_valid.
    assign w_xfer = byte_valid && byte_ready;
    assign w_len  = (byte_in == 8'd0) ? FULL_LEN : (ADDR_W+1)'(byte_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BOOT:    if (load_req) w_next = S_GET_LEN;
            S_GET_LEN: if (w_xfer)   w_next = S_GET_HI;
            S_GET_HI:  if (w_xfer)   w_next = S_GET_LO;
            S_GET_LO:  if (w_xfer)   w_next = S_WRITE;
            S_WRITE:   w_next = (r_remaining == (ADDR_W+1)'(1)) ? S_DONE : S_GET_HI;
            S_DONE:    w_next = S_RUN;
            S_RUN:     if (load_req) w_next = S_GET_LEN;
            default:   w_next = S_BOOT;
        endcase
    end

    // The half-assembled high byte lives apart from r_word so mem_data keeps
    // showing the last complete word until the next one is assembled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_words     <= '0;
            r_wr_ptr    <= '0;
            r_hi        <= '0;
            r_word      <= '0;
        end else begin
            case (r_state)
                S_GET_LEN: begin
                    if (w_xfer) begin
                        r_remaining <= w_len;
                        r_wr_ptr    <= '0;
                        r_words     <= '0;
                    end
                end
                S_GET_HI: begin
                    if (w_xfer) r_hi <= byte_in;
                end
                S_GET_LO: begin
                    if (w_xfer) r_word <= {r_hi, byte_in};
                end
                S_WRITE: begin
                    r_wr_ptr    <= r_wr_ptr + 1'b1;
                    r_words     <= r_words + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        cpu_stall  = 1'b1;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        case (r_state)
            S_BOOT: ;
            S_GET_LEN, S_GET_HI, S_GET_LO: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
                mem_addr   = r_wr_ptr;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                load_busy = 1'b1;
                mem_addr  = r_wr_ptr;
            end
            S_DONE: begin
                load_busy = 1'b1;
                load_done = 1'b1;
                mem_addr  = pc;
            end
            S_RUN: begin
                cpu_stall = 1'b0;
                mem_addr  = pc;
            end
            default: ;
        endcase
    end

    assign mem_data     = r_word;
    assign words_loaded = r_words;
    assign dbg_state    = r_state;
    assign dbg_wr_ptr   = r_wr_ptr;

endmodule

// File: doc/instr_loader_ctrl.md
# instr_loader_ctrl

Boot-loader and access sequencer for the 256×16 instruction memory. The block owns the memory's address, write-data and write-enable lines. It sequences a byte-stream program load (length byte, then big-endian 16-bit words) into consecutive addresses while stalling the CPU, then hands the read port to the CPU program counter. It sits between the host byte link, the CPU fetch stage and the instruction memory.

## Interface
- ADDR_W, 8, instruction memory address width (depth 2^ADDR_W)
- DATA_W, 16, instruction width; fixed at 2 bytes per word
- clk  in  1  system clock, all activity on rising edge
- rst_n  in  1  synchronous, active-low reset
- load_req  in  1  single-cycle request to start a (re)load
- byte_in  in  8  host byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  block accepts byte this cycle
- pc  in  ADDR_W  CPU fetch address
- mem_addr  out  ADDR_W  to memory address port
- mem_data  out  DATA_W  to memory write-data port
- mem_we  out  1  to memory write enable
- cpu_stall  out  1  CPU must hold pc and ignore instruction_out
- load_busy  out  1  load in progress
- load_done  out  1  one-cycle pulse at end of load
- words_loaded  out  ADDR_W+1  words written by the last/current load

## Operation
- States:
  - BOOT (reset state)
  - GET_LEN
  - GET_HI
  - GET_LO
  - WRITE
  - DONE
  - RUN
- Byte transfer occurs when byte_valid & byte_ready. byte_ready=1 only in GET_LEN, GET_HI and GET_LO.
- BOOT: cpu_stall=1, mem_we=0, mem_addr=0. On load_req → GET_LEN.
- GET_LEN: on transfer, remaining = (byte_in==0) ? 256 : byte_in. Also clear wr_ptr=0 and words_loaded=0, then → GET_HI.
- GET_HI: on transfer, word[15:8]=byte_in → GET_LO.
- GET_LO: on transfer, word[7:0]=byte_in → WRITE.
- WRITE: drives mem_we=1, mem_addr=wr_ptr, mem_data=word for exactly one cycle.
  - Then wr_ptr+=1 (mod 256) and words_loaded+=1.
  - Then remaining-=1; if remaining becomes 0 → DONE, else → GET_HI.
- DONE: load_done=1, mem_addr=pc, mem_we=0 (primes the first fetch) → RUN.
- RUN: cpu_stall=0, mem_addr=pc (combinational pass-through), mem_we=0. On load_req → GET_LEN.
- load_req outside BOOT/RUN is ignored; a load is never restarted mid-stream.
- load_busy=1 in GET_LEN, GET_HI, GET_LO, WRITE and DONE.
- cpu_stall=1 in every state except RUN.
- mem_data holds its last assembled word outside WRITE. mem_we is 0 in every state except WRITE.
- wr_ptr is ADDR_W bits; a 256-word load writes addresses 0..255 and wraps wr_ptr to 0.
- remaining and words_loaded are 9 bits, so the 256 count is representable.

## Timing
- Reset (rst_n=0 at a clock edge) forces:
  - state=BOOT, mem_we=0, byte_ready=0, cpu_stall=1, load_busy=0, load_done=0
  - wr_ptr=0, remaining=0, words_loaded=0, mem_data=0, mem_addr=0
- Reset mid-load aborts immediately with no write on that cycle. Memory keeps any words already written.
- With byte_valid held high, the length byte is accepted in cycle 0. Each word then takes 3 cycles (HI, LO, WRITE).
  - load_done pulses in cycle 3N+1.
  - cpu_stall falls in cycle 3N+2.
- Memory read latency is 1 cycle. In RUN, instruction_out for pc is valid the cycle after pc is presented. DONE guarantees valid data at the first RUN cycle.
- A byte_valid gap stalls the FSM in its GET_* state with no timeout.
- load_req and byte_valid in the same RUN cycle: only the state change occurs; the byte is not consumed (byte_ready=0 in RUN).
- The only input-to-output combinational path is pc → mem_addr, in DONE and RUN.

## Test plan
- Reset, then idle 5 cycles → cpu_stall=1, mem_we=0, byte_ready=0, load_busy=0.
- load_req; stream 0x02,0x12,0x34,0xAB,0xCD continuously:
  - mem_we pulses at addr 0 with data 0x1234, then at addr 1 with 0xABCD
  - load_done at cycle 7, words_loaded=2
  - RUN with pc=1 → instruction_out=0xABCD the next cycle
- Length byte 0x00 followed by 512 bytes → 256 writes to addrs 0..255, words_loaded=256, wr_ptr=0 afterwards.
- Random byte_valid gaps during a 3-word load → identical memory contents and no byte lost or duplicated. byte_ready is 0 in WRITE.
- Assert rst_n=0 after the HI byte of word 1 → no write of word 1, state BOOT, cpu_stall=1. Word 0 remains in memory.
- load_req pulses during GET_HI → ignored. load_req in RUN after a load → cpu_stall=1 next cycle, new load overwrites from addr 0.
